// File: rtl/temp_sense.sv
// temp_sense: periodic serial temperature read with debounced 36/38 C flags.
// Optional macro TEMP_SENSE_PARITY_EN adds an even-parity bit to each frame.
module temp_sense #(
    parameter int SAMPLE_DIV = 1000,
    parameter int DEBOUNCE_N = 3,
    parameter int HYST       = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sdi,
    output logic       cs_n,
    output logic       sck,
    output logic [7:0] sample,
    output logic       sample_valid,
    output logic       temp36,
    output logic       temp38,
    output logic       fault
);

`ifdef TEMP_SENSE_PARITY_EN
    localparam int F = 9;
`else
    localparam int F = 8;
`endif

    localparam int CW = $clog2(SAMPLE_DIV);
    localparam int SW = $clog2(2 * F);
    localparam logic [CW-1:0] DIV_LAST = CW'(SAMPLE_DIV - 1);
    localparam logic [SW-1:0] BIT_LAST = SW'(2 * F - 1);
    localparam logic [3:0] DEB_N = 4'(DEBOUNCE_N);

    localparam int T36 = 36;
    localparam int T38 = 38;
    localparam int C36 = T36 - HYST;
    localparam int C38 = T38 - HYST;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] div_q, div_d;
    logic [SW-1:0] bit_q, bit_d;
    logic [F-1:0]  shreg_q, shreg_d;
    logic          cs_n_q, cs_n_d;
    logic          sck_q, sck_d;
    logic [7:0]    sample_q, sample_d;
    logic          valid_q, valid_d;
    logic          t36_q, t36_d;
    logic          t38_q, t38_d;
    logic [3:0]    cnt36_q, cnt36_d;
    logic [3:0]    cnt38_q, cnt38_d;

    logic              frame_done;
    logic              parity_ok;
    logic              accept;
    logic [7:0]        data;
    logic signed [7:0] temp_s;
    logic              set36, clr36, set38, clr38;
    logic [4:0]        deb36, deb38;

    // One debounce step: count samples arguing for the opposite flag value.
    function automatic logic [4:0] debounce(
        input logic       flag,
        input logic [3:0] cnt,
        input logic       set_c,
        input logic       clr_c
    );
        logic       hit;
        logic [3:0] nxt;
        logic [4:0] res;
        hit = flag ? clr_c : set_c;
        nxt = cnt + 4'd1;
        if (!hit) begin
            res = {flag, 4'd0};
        end else if (nxt == DEB_N) begin
            res = {~flag, 4'd0};
        end else begin
            res = {flag, nxt};
        end
        return res;
    endfunction

    assign data       = shreg_q[F-1 -: 8];
    assign temp_s     = data;
    assign frame_done = (state_q == DONE);

`ifdef TEMP_SENSE_PARITY_EN
    assign parity_ok = ~(^shreg_q);
`else
    assign parity_ok = 1'b1;
`endif

    assign accept = frame_done & parity_ok;

    // Read sequencer: free-running interval counter plus frame shifter.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        div_d   = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                if (div_q == DIV_LAST) begin
                    state_d = SETUP;
                    bit_d   = '0;
                end
            end
            SETUP: begin
                state_d = SHIFT;
                bit_d   = '0;
            end
            SHIFT: begin
                if (bit_q[0]) begin
                    shreg_d = {shreg_q[F-2:0], sdi};
                end
                if (bit_q == BIT_LAST) begin
                    state_d = DONE;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        cs_n_d = ~((state_d == SETUP) || (state_d == SHIFT));
        sck_d  = (state_d == SHIFT) && bit_d[0];
    end

    // Sample capture and per-threshold debounce on accepted frames.
    always_comb begin
        set36 = (int'(temp_s) >= T36);
        clr36 = (int'(temp_s) < C36);
        set38 = (int'(temp_s) >= T38);
        clr38 = (int'(temp_s) < C38);
        deb36 = debounce(t36_q, cnt36_q, set36, clr36);
        deb38 = debounce(t38_q, cnt38_q, set38, clr38);
        sample_d = sample_q;
        valid_d  = accept;
        t36_d    = t36_q;
        t38_d    = t38_q;
        cnt36_d  = cnt36_q;
        cnt38_d  = cnt38_q;
        if (accept) begin
            sample_d = data;
            {t36_d, cnt36_d} = deb36;
            {t38_d, cnt38_d} = deb38;
        end
    end

    // Sequencer and sensor-pin state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            cs_n_q  <= 1'b1;
            sck_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            cs_n_q  <= cs_n_d;
            sck_q   <= sck_d;
        end
    end

    // Result registers and debounce state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q <= '0;
            valid_q  <= 1'b0;
            t36_q    <= 1'b0;
            t38_q    <= 1'b0;
            cnt36_q  <= '0;
            cnt38_q  <= '0;
        end else begin
            sample_q <= sample_d;
            valid_q  <= valid_d;
            t36_q    <= t36_d;
            t38_q    <= t38_d;
            cnt36_q  <= cnt36_d;
            cnt38_q  <= cnt38_d;
        end
    end

`ifdef TEMP_SENSE_PARITY_EN
    logic fault_q, fault_d;

    // Sticky frame-error flag, cleared only by reset.
    always_comb begin
        fault_d = fault_q | (frame_done & ~parity_ok);
    end

    // Fault register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign cs_n         = cs_n_q;
    assign sck          = sck_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign temp36       = t36_q;
    assign temp38       = t38_q;

endmodule

// File: tb/tb_temp_sense.sv
// Directed bench for temp_sense: timing, debounce, hysteresis, reset abort
// and (with TEMP_SENSE_PARITY_EN) parity rejection.
module tb_temp_sense;

    localparam int SD = 40;
`ifdef TEMP_SENSE_PARITY_EN
    localparam int F = 9;
`else
    localparam int F = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sdi = 1'b0;
    logic       cs_n;
    logic       sck;
    logic [7:0] sample;
    logic       sample_valid;
    logic       temp36;
    logic       temp38;
    logic       fault;

    int vectors     = 0;
    int miscompares = 0;

    logic [8:0] fr = '0;
    int         nbits = 0;
    logic       sck_prev = 1'b0;

    temp_sense #(
        .SAMPLE_DIV(SD),
        .DEBOUNCE_N(3),
        .HYST      (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sdi         (sdi),
        .cs_n        (cs_n),
        .sck         (sck),
        .sample      (sample),
        .sample_valid(sample_valid),
        .temp36      (temp36),
        .temp38      (temp38),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    // Sensor model: MSB first, next bit presented after each sck fall.
    always @(negedge clk) begin
        if (cs_n) nbits = 0;
        else if (!sck && sck_prev) nbits++;
        sck_prev = sck;
        sdi = (nbits < F) ? fr[F-1-nbits] : 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_frame(input logic [7:0] d, input bit bad);
`ifdef TEMP_SENSE_PARITY_EN
        fr = {d, (^d) ^ bad};
`else
        fr = {1'b0, d};
`endif
    endtask

    task automatic frame(input logic [7:0] d, input bit bad,
                         output int low, output int rises, output int svn);
        int   t;
        logic p;
        set_frame(d, bad);
        low = 0; rises = 0; svn = 0; t = 0; p = 1'b0;
        while (cs_n && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("start_timeout", cs_n, 0);
        while (!cs_n && low < 100) begin
            if (sck && !p) rises++;
            p = sck;
            low++;
            @(negedge clk);
        end
        repeat (4) begin
            if (sample_valid) svn++;
            @(negedge clk);
        end
    endtask

    task automatic rd(input string tag, input logic [7:0] d,
                      input logic e36, input logic e38);
        int low, rises, svn;
        frame(d, 1'b0, low, rises, svn);
        chk({tag, "_sv"}, svn, 1);
        chk({tag, "_sample"}, sample, d);
        chk({tag, "_t36"}, temp36, e36);
        chk({tag, "_t38"}, temp38, e38);
    endtask

    initial begin
        int low, rises, svn, n, svseen;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_sck", sck, 0);
        chk("rst_sample", sample, 0);
        chk("rst_sv", sample_valid, 0);
        chk("rst_t36", temp36, 0);
        chk("rst_t38", temp38, 0);
        chk("rst_fault", fault, 0);
        rst = 1'b0;

        frame(8'd25, 1'b0, low, rises, svn);
        chk("tm_cs_low", low, 1 + 2 * F);
        chk("tm_sck_rises", rises, F);
        chk("tm_sv", svn, 1);
        chk("tm_sample", sample, 25);
        chk("tm_t36", temp36, 0);
        chk("tm_t38", temp38, 0);

        rd("db_a", 8'd36, 0, 0);
        rd("db_b", 8'd35, 0, 0);
        rd("db_c", 8'd36, 0, 0);
        rd("db_d", 8'd25, 0, 0);
        rd("db_e", 8'd36, 0, 0);
        rd("db_f", 8'd36, 0, 0);
        rd("db_g", 8'd36, 1, 0);

        rd("hy_a", 8'd35, 1, 0);
        rd("hy_b", 8'd35, 1, 0);
        rd("hy_c", 8'd35, 1, 0);
        rd("hy_d", 8'd34, 1, 0);
        rd("hy_e", 8'd34, 1, 0);
        rd("hy_f", 8'd34, 0, 0);

        rd("bt_a", 8'd40, 0, 0);
        rd("bt_b", 8'd40, 0, 0);
        rd("bt_c", 8'd40, 1, 1);
        rd("bt_d", 8'd37, 1, 1);
        rd("bt_e", 8'd37, 1, 1);
        rd("bt_f", 8'd37, 1, 1);
        rd("bt_g", 8'd36, 1, 1);
        rd("bt_h", 8'd36, 1, 1);
        rd("bt_i", 8'd36, 1, 0);

        rd("ng_a", 8'hF6, 1, 0);
        rd("ng_b", 8'hF6, 1, 0);
        rd("ng_c", 8'hF6, 0, 0);
        rd("ng_d", 8'hF6, 0, 0);
        rd("ng_e", 8'hF6, 0, 0);
        rd("ng_f", 8'hF6, 0, 0);
        chk("ng_fault", fault, 0);

`ifdef TEMP_SENSE_PARITY_EN
        rd("pa_a", 8'd39, 0, 0);
        frame(8'd38, 1'b1, low, rises, svn);
        chk("pa_bad_sv", svn, 0);
        chk("pa_bad_sample", sample, 39);
        chk("pa_bad_fault", fault, 1);
        chk("pa_bad_t36", temp36, 0);
        rd("pa_b", 8'd38, 0, 0);
        rd("pa_c", 8'd38, 1, 1);
        chk("pa_sticky", fault, 1);
`endif

        set_frame(8'd25, 1'b0);
        n = 0;
        while (cs_n && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk("ra_sck_before", sck, 1);
        rst = 1'b1;
        #1;
        chk("ra_cs_n", cs_n, 1);
        chk("ra_sck", sck, 0);
        @(negedge clk);
        chk("ra_sv", sample_valid, 0);
        rst = 1'b0;
        n = 0;
        svseen = 0;
        while (cs_n && n < 200) begin
            @(negedge clk);
            n++;
            if (sample_valid) svseen++;
        end
        chk("ra_restart", n, SD);
        chk("ra_no_sv", svseen, 0);
        chk("ra_sample", sample, 0);
        chk("ra_fault", fault, 0);
        chk("ra_t36", temp36, 0);
        rd("ra_next", 8'd25, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
